rx_packet_ctrl: RTL and testbench
=================================

Name: rx_packet_ctrl

Overview:
- Sequences the Gen2 RX demodulator. Holds the demodulator in reset while TX is busy and re-arms it between packets.
- Consumes the serial bitout/bitclk stream and frames it into one command packet. Decodes the opcode prefix to find the expected packet length.
- Presents the framed packet, its bit count, its type and the latched TR cal value to the command decoder through a valid/ack handshake.

Parameters:
- DATA_W, 64, width of the packet shift register; bits beyond DATA_W are counted but shifted out of the top.
- ARM_CYCLES, 2, number of clk cycles rx_reset is held high on each re-arm (range 1..15).
- MAX_BITS, 127, bit count limit; reaching it with no length match is a framing error.

Ports:
- clk  input  1  system clock; all logic is clocked on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- bitin  input  1  demodulated data bit (from demodulator bitout).
- bitclk  input  1  demodulator bit strobe; a bit is valid on its rising edge; synchronous to clk.
- rx_overflow  input  1  demodulator end-of-frame/overflow indication (rx_overflow_reset).
- trcal_in  input  10  demodulator TR cal measurement.
- tx_busy  input  1  transmitter active; the demodulator must be held in reset.
- pkt_ack  input  1  consumer accepts the current packet.
- rx_reset  output  1  active-high reset to the demodulator.
- pkt_data  output  DATA_W  received bits, MSB-first; the newest bit is at bit 0.
- pkt_bits  output  7  number of bits received.
- pkt_type  output  3  decoded type: 0 QueryRep, 1 ACK, 2 Query, 3 QueryAdjust, 4 Req_RN, 7 variable/unknown.
- pkt_valid  output  1  packet is complete and held stable.
- pkt_error  output  1  one-cycle pulse on a framing error.
- trcal_out  output  10  TR cal value captured on the first bit of the packet.

Behaviour:
- Reset (reset=0, async) clears all outputs to 0, except rx_reset=1 so the demodulator is held while the controller is in reset. State goes to ARM with the arm counter cleared.
- Bit strobe: bitclk is registered; bit_stb = bitclk & ~bitclk_q (one pulse per rising edge, one cycle after the edge).
- ARM state:
  - rx_reset=1 for ARM_CYCLES cycles.
  - Then clear pkt_data and pkt_bits and go to LISTEN.
  - While tx_busy=1 the state stays in ARM with the arm counter held at 0.
- LISTEN state (rx_reset=0):
  - On bit_stb: pkt_data <= {pkt_data[DATA_W-2:0], bitin}; pkt_bits++ (saturates at 127).
  - If pkt_bits was 0 on that strobe, capture trcal_out <= trcal_in.
- Opcode decode, evaluated on the updated shift register:
  - After 2 bits: 00 -> QueryRep, expected length 4; 01 -> ACK, expected 18.
  - After 4 bits: 1000 -> Query, expected 22; 1001 -> QueryAdjust, expected 9.
  - After 8 bits: 11000001 -> Req_RN, expected 40.
  - Any other prefix (1010, 1011, 11xxxxxx other than 11000001) is type 7 with no expected length; its end is marked by rx_overflow.
- Completion:
  - pkt_bits reaching the expected length -> DONE, pkt_valid=1, rx_reset=1.
  - Type 7 packet and rx_overflow=1 with pkt_bits>0 -> DONE.
- Error: pkt_error pulses, then re-arm with pkt_valid staying 0, in either case:
  - rx_overflow=1 during LISTEN on a fixed-length type with 0 < pkt_bits < expected;
  - pkt_bits reaching MAX_BITS without completion.
- rx_overflow=1 with pkt_bits=0: silent re-arm (no error, no valid).
- Simultaneous strobe and overflow in the same cycle: the bit is shifted first, then completion or error is evaluated on the updated count.
- DONE state:
  - pkt_data, pkt_bits, pkt_type and trcal_out are frozen.
  - pkt_valid stays high until pkt_ack=1 is seen on a clk edge; pkt_valid then drops next cycle and the state goes to ARM.
  - Strobes during DONE are ignored.
- tx_busy rising in LISTEN aborts the packet without error: go to ARM. tx_busy in DONE is held off until ack.
- Latency: pkt_valid rises 1 cycle after the final bit_stb.

Test Plan:
- Reset released with tx_busy=0 -> rx_reset=1 for exactly 2 cycles, then 0; all outputs 0.
- Bits 1,0,0,0 followed by 18 further bits -> pkt_type=2, pkt_bits=22, pkt_valid=1 one cycle after the 22nd strobe; pkt_data[21:0] equals the sent bits.
- Bits 0,0,1,1 -> pkt_type=0, pkt_bits=4, pkt_data[3:0]=4'b0011. pkt_valid is held through 5 idle cycles, drops the cycle after pkt_ack, then rx_reset pulses.
- ACK prefix 01 plus 5 bits, then rx_overflow=1 -> pkt_error pulses once, pkt_valid=0, re-arm occurs.
- Prefix 1010 plus 30 bits, then rx_overflow -> pkt_type=7, pkt_bits=34, pkt_valid=1; trcal_out equals the trcal_in value present at the first strobe (e.g. 10'h155).
- tx_busy=1 mid-LISTEN after 3 bits -> no error, rx_reset held high while busy; after tx_busy=0, rx_reset stays high 2 more cycles then releases, with pkt_bits=0. Also assert reset=0 mid-packet -> outputs clear immediately.

Source files
------------

// File: rtl/rx_packet_ctrl.sv
// rtl/rx_packet_ctrl.sv - Gen2 RX demodulator sequencer and command packet framer
//
// Holds the demodulator in reset while the transmitter is busy, re-arms it
// between packets, frames the serial bitout/bitclk stream into one command
// packet and hands that packet to the command decoder through a
// valid/ack handshake.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous active-low reset
//   bitin        demodulated data bit
//   bitclk       demodulator bit strobe (rising edge marks a valid bit)
//   rx_overflow  demodulator end-of-frame / overflow indication
//   trcal_in     demodulator TR cal measurement
//   tx_busy      transmitter active, demodulator must stay in reset
//   pkt_ack      consumer accepts the presented packet
//   rx_reset     active-high reset to the demodulator
//   pkt_data     received bits, newest bit at bit 0
//   pkt_bits     number of bits received (saturates at 127)
//   pkt_type     decoded packet type (7 = variable length / unknown)
//   pkt_valid    packet complete and held stable until acknowledged
//   pkt_error    one-cycle pulse on a framing error
//   trcal_out    TR cal value captured with the first bit of the packet
module rx_packet_ctrl #(
    parameter int DATA_W     = 64,
    parameter int ARM_CYCLES = 2,
    parameter int MAX_BITS   = 127
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bitin,
    input  logic              bitclk,
    input  logic              rx_overflow,
    input  logic [9:0]        trcal_in,
    input  logic              tx_busy,
    input  logic              pkt_ack,
    output logic              rx_reset,
    output logic [DATA_W-1:0] pkt_data,
    output logic [6:0]        pkt_bits,
    output logic [2:0]        pkt_type,
    output logic              pkt_valid,
    output logic              pkt_error,
    output logic [9:0]        trcal_out
);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_LISTEN,
        ST_DONE
    } state_t;

    localparam logic [2:0] TYPE_QUERYREP = 3'd0;
    localparam logic [2:0] TYPE_ACK      = 3'd1;
    localparam logic [2:0] TYPE_QUERY    = 3'd2;
    localparam logic [2:0] TYPE_QUERYADJ = 3'd3;
    localparam logic [2:0] TYPE_REQ_RN   = 3'd4;
    localparam logic [2:0] TYPE_VAR      = 3'd7;

    localparam logic [6:0] LEN_QUERYREP  = 7'd4;
    localparam logic [6:0] LEN_ACK       = 7'd18;
    localparam logic [6:0] LEN_QUERY     = 7'd22;
    localparam logic [6:0] LEN_QUERYADJ  = 7'd9;
    localparam logic [6:0] LEN_REQ_RN    = 7'd40;

    localparam logic [6:0] BITS_SAT      = 7'd127;
    localparam logic [6:0] MAX_B         = 7'(MAX_BITS);
    localparam logic [3:0] ARM_LAST      = 4'(ARM_CYCLES - 1);

    state_t            state;
    logic [3:0]        arm_cnt;
    logic              bitclk_q;
    logic              bit_stb;

    // Decode result of the packet seen so far: type_known once the prefix
    // is resolved, fixed_len when that type has a known length exp_len.
    logic              type_known;
    logic              fixed_len;
    logic [6:0]        exp_len;

    // Post-shift view of the packet for the current cycle. Completion and
    // error decisions are made on these so that a strobe coinciding with
    // rx_overflow is counted before the overflow is judged.
    logic [DATA_W-1:0] data_nxt;
    logic [6:0]        bits_nxt;
    logic              known_nxt;
    logic              fixed_nxt;
    logic [2:0]        type_nxt;
    logic [6:0]        len_nxt;
    logic              len_hit;

    assign bit_stb = bitclk & ~bitclk_q;

    always_comb begin
        data_nxt  = pkt_data;
        bits_nxt  = pkt_bits;
        known_nxt = type_known;
        fixed_nxt = fixed_len;
        type_nxt  = pkt_type;
        len_nxt   = exp_len;

        if (bit_stb) begin
            data_nxt = {pkt_data[DATA_W-2:0], bitin};
            bits_nxt = (pkt_bits == BITS_SAT) ? pkt_bits : pkt_bits + 7'd1;
        end

        // Prefix decode. data_nxt[k-1] is the first bit of a k-bit packet.
        // At 4 bits an unresolved prefix must start with 1; at 8 bits it
        // must start with 11, so only the remaining bits need testing.
        if (bit_stb && !type_known) begin
            case (bits_nxt)
                7'd2: begin
                    if (!data_nxt[1]) begin
                        known_nxt = 1'b1;
                        fixed_nxt = 1'b1;
                        type_nxt  = data_nxt[0] ? TYPE_ACK : TYPE_QUERYREP;
                        len_nxt   = data_nxt[0] ? LEN_ACK : LEN_QUERYREP;
                    end
                end
                7'd4: begin
                    if (!data_nxt[2]) begin
                        known_nxt = 1'b1;
                        if (!data_nxt[1]) begin
                            fixed_nxt = 1'b1;
                            type_nxt  = data_nxt[0] ? TYPE_QUERYADJ : TYPE_QUERY;
                            len_nxt   = data_nxt[0] ? LEN_QUERYADJ : LEN_QUERY;
                        end else begin
                            fixed_nxt = 1'b0;
                            type_nxt  = TYPE_VAR;
                            len_nxt   = 7'd0;
                        end
                    end
                end
                7'd8: begin
                    known_nxt = 1'b1;
                    if (data_nxt[7:0] == 8'b1100_0001) begin
                        fixed_nxt = 1'b1;
                        type_nxt  = TYPE_REQ_RN;
                        len_nxt   = LEN_REQ_RN;
                    end else begin
                        fixed_nxt = 1'b0;
                        type_nxt  = TYPE_VAR;
                        len_nxt   = 7'd0;
                    end
                end
                default: ;
            endcase
        end

        len_hit = known_nxt && fixed_nxt && (bits_nxt == len_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ARM;
            arm_cnt    <= 4'd0;
            bitclk_q   <= 1'b0;
            rx_reset   <= 1'b1;
            pkt_data   <= '0;
            pkt_bits   <= 7'd0;
            pkt_type   <= 3'd0;
            pkt_valid  <= 1'b0;
            pkt_error  <= 1'b0;
            trcal_out  <= 10'd0;
            type_known <= 1'b0;
            fixed_len  <= 1'b0;
            exp_len    <= 7'd0;
        end else begin
            bitclk_q  <= bitclk;
            pkt_error <= 1'b0;

            case (state)
                ST_ARM: begin
                    rx_reset <= 1'b1;
                    if (tx_busy) begin
                        // The arm window only starts counting once TX is idle.
                        arm_cnt <= 4'd0;
                    end else if (arm_cnt == ARM_LAST) begin
                        arm_cnt    <= 4'd0;
                        rx_reset   <= 1'b0;
                        pkt_data   <= '0;
                        pkt_bits   <= 7'd0;
                        pkt_type   <= 3'd0;
                        type_known <= 1'b0;
                        fixed_len  <= 1'b0;
                        exp_len    <= 7'd0;
                        state      <= ST_LISTEN;
                    end else begin
                        arm_cnt <= arm_cnt + 4'd1;
                    end
                end

                ST_LISTEN: begin
                    if (tx_busy) begin
                        // Abort silently; the partial packet is discarded.
                        rx_reset <= 1'b1;
                        arm_cnt  <= 4'd0;
                        state    <= ST_ARM;
                    end else begin
                        pkt_data   <= data_nxt;
                        pkt_bits   <= bits_nxt;
                        pkt_type   <= type_nxt;
                        type_known <= known_nxt;
                        fixed_len  <= fixed_nxt;
                        exp_len    <= len_nxt;
                        if (bit_stb && pkt_bits == 7'd0) begin
                            trcal_out <= trcal_in;
                        end

                        if (len_hit) begin
                            pkt_valid <= 1'b1;
                            rx_reset  <= 1'b1;
                            state     <= ST_DONE;
                        end else if (rx_overflow) begin
                            rx_reset <= 1'b1;
                            arm_cnt  <= 4'd0;
                            if (bits_nxt == 7'd0) begin
                                state <= ST_ARM;
                            end else if (known_nxt && !fixed_nxt) begin
                                // Variable-length packets end on overflow.
                                pkt_valid <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                // Short fixed-length packet, or a prefix that
                                // never resolved: framing error.
                                pkt_error <= 1'b1;
                                state     <= ST_ARM;
                            end
                        end else if (bits_nxt >= MAX_B) begin
                            pkt_error <= 1'b1;
                            rx_reset  <= 1'b1;
                            arm_cnt   <= 4'd0;
                            state     <= ST_ARM;
                        end
                    end
                end

                ST_DONE: begin
                    // Packet registers are frozen here; strobes, overflow and
                    // tx_busy are all ignored until the consumer acknowledges.
                    if (pkt_ack) begin
                        pkt_valid <= 1'b0;
                        arm_cnt   <= 4'd0;
                        state     <= ST_ARM;
                    end
                end

                default: begin
                    rx_reset <= 1'b1;
                    arm_cnt  <= 4'd0;
                    state    <= ST_ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb/tb_rx_packet_ctrl.sv - self-checking bench for rx_packet_ctrl
`timescale 1ns/1ps
module tb_rx_packet_ctrl;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              bitin = 1'b0;
    logic              bitclk = 1'b0;
    logic              rx_overflow = 1'b0;
    logic [9:0]        trcal_in = 10'd0;
    logic              tx_busy = 1'b0;
    logic              pkt_ack = 1'b0;
    logic              rx_reset;
    logic [DATA_W-1:0] pkt_data;
    logic [6:0]        pkt_bits;
    logic [2:0]        pkt_type;
    logic              pkt_valid;
    logic              pkt_error;
    logic [9:0]        trcal_out;

    rx_packet_ctrl #(.DATA_W(DATA_W), .ARM_CYCLES(2), .MAX_BITS(127)) dut (
        .clk(clk), .reset(reset), .bitin(bitin), .bitclk(bitclk),
        .rx_overflow(rx_overflow), .trcal_in(trcal_in), .tx_busy(tx_busy),
        .pkt_ack(pkt_ack), .rx_reset(rx_reset), .pkt_data(pkt_data),
        .pkt_bits(pkt_bits), .pkt_type(pkt_type), .pkt_valid(pkt_valid),
        .pkt_error(pkt_error), .trcal_out(trcal_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the outputs must show after the next rising edge.
    // m_phase: 0 = not listening/done (only valid/error checked),
    //          1 = listening, 2 = packet presented.
    bit          m_en = 1'b0;
    int          m_phase = 0;
    bit          m_error = 1'b0;
    int          m_bits = 0;
    logic [63:0] m_data = '0;
    logic [9:0]  m_trcal = '0;
    int          m_type = -1;
    bit          sent[$];
    bit          pq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (m_en) begin
            check("pkt_error", pkt_error, m_error);
            check("pkt_valid", pkt_valid, m_phase == 2);
            if (m_phase != 0) begin
                check("rx_reset", rx_reset, m_phase == 2);
                check("pkt_bits", pkt_bits, m_bits);
                check("pkt_data", pkt_data, m_data);
            end
            if (m_phase == 2) begin
                check("pkt_type", pkt_type, m_type);
                check("trcal_out", trcal_out, m_trcal);
            end
        end
    end

    // Opcode table applied to the bits sent so far.
    function automatic void decode(output int typ, output int len);
        typ = -1;
        len = 0;
        if (sent.size() >= 2 && sent[0] == 1'b0) begin
            typ = sent[1] ? 1 : 0;
            len = sent[1] ? 18 : 4;
        end else if (sent.size() >= 4 && sent[1] == 1'b0) begin
            if (sent[2] == 1'b0) begin
                typ = sent[3] ? 3 : 2;
                len = sent[3] ? 9 : 22;
            end else begin
                typ = 7;
            end
        end else if (sent.size() >= 8) begin
            if ({sent[2], sent[3], sent[4], sent[5], sent[6], sent[7]} == 6'b000001) begin
                typ = 4;
                len = 40;
            end else begin
                typ = 7;
            end
        end
    endfunction

    function automatic void ovf_outcome(input int typ);
        if (m_bits == 0) m_phase = 0;
        else if (typ == 7) m_phase = 2;
        else begin
            m_error = 1'b1;
            m_phase = 0;
        end
    endfunction

    function automatic void push_bits(input int v, input int w);
        for (int i = w - 1; i >= 0; i--) pq.push_back(v[i]);
    endfunction

    function automatic void push_rand(input int n);
        for (int i = 0; i < n; i++) pq.push_back(bit'($urandom_range(0, 1)));
    endfunction

    task automatic wait_listen();
        int n;
        n = 0;
        @(negedge clk);
        while (rx_reset !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rx_reset !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_listen: rx_reset still %0b after 40 cycles", rx_reset);
        end
        sent.delete();
        m_bits  = 0;
        m_data  = '0;
        m_type  = -1;
        m_phase = 1;
    endtask

    task automatic send_bit(input bit b, input bit ovf, input logic [9:0] tc);
        int typ, len;
        bitin       = b;
        bitclk      = 1'b1;
        rx_overflow = ovf;
        trcal_in    = tc;
        if (m_phase == 1) begin
            if (m_bits == 0) m_trcal = tc;
            sent.push_back(b);
            if (m_bits < 127) m_bits = m_bits + 1;
            m_data = {m_data[62:0], b};
            decode(typ, len);
            if (typ >= 0) m_type = typ;
            if (len != 0 && m_bits == len) m_phase = 2;
            else if (ovf) ovf_outcome(typ);
            else if (m_bits >= 127) begin
                m_error = 1'b1;
                m_phase = 0;
            end
        end
        @(negedge clk);
        bitclk      = 1'b0;
        rx_overflow = 1'b0;
        m_error     = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_overflow();
        int typ, len;
        rx_overflow = 1'b1;
        decode(typ, len);
        if (m_phase == 1) ovf_outcome(typ);
        @(negedge clk);
        rx_overflow = 1'b0;
        m_error     = 1'b0;
        @(negedge clk);
    endtask

    task automatic play(input bit ovf_end, input bit ovf_last, input logic [9:0] tc_first);
        wait_listen();
        for (int i = 0; i < pq.size(); i++) begin
            send_bit(pq[i], ovf_end && ovf_last && (i == pq.size() - 1),
                     (i == 0) ? tc_first : 10'($urandom));
        end
        if (ovf_end && !ovf_last) send_overflow();
    endtask

    task automatic finish_done(input int hold);
        if (m_phase == 2) begin
            repeat (hold) @(negedge clk);
            pkt_ack = 1'b1;
            m_phase = 0;
            @(negedge clk);
            pkt_ack = 1'b0;
        end
    endtask

    task automatic run_random(input int kind);
        bit ovf_end, ovf_last;
        int n;
        pq.delete();
        ovf_end  = 1'b0;
        ovf_last = bit'($urandom_range(0, 1));
        case (kind)
            0: begin push_bits(0, 2); push_rand(2); end
            1: begin push_bits(1, 2); push_rand(16); end
            2: begin push_bits(8, 4); push_rand(18); end
            3: begin push_bits(9, 4); push_rand(5); end
            4: begin push_bits(8'hC1, 8); push_rand(32); end
            5: begin
                push_bits($urandom_range(10, 11), 4);
                push_rand($urandom_range(0, 40));
                ovf_end = 1'b1;
            end
            6: begin
                n = $urandom_range(0, 63);
                if (n == 1) n = 2;
                push_bits(8'hC0 | n, 8);
                push_rand($urandom_range(0, 20));
                ovf_end = 1'b1;
            end
            default: begin
                case ($urandom_range(0, 4))
                    0: begin push_bits(0, 2); push_rand($urandom_range(0, 1)); end
                    1: begin push_bits(1, 2); push_rand($urandom_range(0, 15)); end
                    2: begin push_bits(8, 4); push_rand($urandom_range(0, 17)); end
                    3: begin push_bits(9, 4); push_rand($urandom_range(0, 4)); end
                    default: begin push_bits(8'hC1, 8); push_rand($urandom_range(0, 31)); end
                endcase
                ovf_end = 1'b1;
            end
        endcase
        if (!ovf_end) ovf_last = 1'b0;
        play(ovf_end, ovf_last, 10'($urandom));
        finish_done($urandom_range(0, 5));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_v;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_reset", rx_reset, 1);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_pkt_error", pkt_error, 0);
        check("rst_pkt_bits", pkt_bits, 0);
        check("rst_pkt_data", pkt_data, 0);
        check("rst_pkt_type", pkt_type, 0);
        check("rst_trcal_out", trcal_out, 0);
        reset = 1'b1;
        @(negedge clk);
        check("arm_hold", rx_reset, 1);
        @(negedge clk);
        check("arm_release", rx_reset, 0);
        check("arm_bits", pkt_bits, 0);
        m_en = 1'b1;

        // Query: 1000 + 18 bits
        pq.delete();
        push_bits(4'b1000, 4);
        push_rand(18);
        play(1'b0, 1'b0, 10'($urandom));
        check("query_valid", pkt_valid, 1);
        check("query_type", pkt_type, 2);
        check("query_bits", pkt_bits, 22);
        exp_v = '0;
        foreach (pq[i]) exp_v = {exp_v[62:0], pq[i]};
        check("query_data", pkt_data[21:0], exp_v[21:0]);
        finish_done(2);

        // QueryRep 0011 held through idle cycles, ignored strobes and tx_busy
        pq.delete();
        push_bits(4'b0011, 4);
        play(1'b0, 1'b0, 10'h2AA);
        check("qr_type", pkt_type, 0);
        check("qr_bits", pkt_bits, 4);
        check("qr_data", pkt_data[3:0], 4'b0011);
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bitclk = ~bitclk;
            @(negedge clk);
        end
        bitclk = 1'b0;
        check("qr_held", pkt_valid, 1);
        pkt_ack = 1'b1;
        m_phase = 0;
        @(negedge clk);
        pkt_ack = 1'b0;
        check("qr_ack_drop", pkt_valid, 0);
        check("qr_rearm", rx_reset, 1);
        repeat (3) @(negedge clk);
        check("qr_busy_hold", rx_reset, 1);
        tx_busy = 1'b0;

        // ACK prefix cut short by overflow
        pq.delete();
        push_bits(2'b01, 2);
        push_rand(5);
        play(1'b1, 1'b0, 10'($urandom));
        check("ack_err_rearm", rx_reset, 1);
        check("ack_err_novalid", pkt_valid, 0);

        // Variable-length 1010 + 30 bits ended by overflow
        pq.delete();
        push_bits(4'b1010, 4);
        push_rand(30);
        play(1'b1, 1'b0, 10'h155);
        check("var_valid", pkt_valid, 1);
        check("var_type", pkt_type, 7);
        check("var_bits", pkt_bits, 34);
        check("var_trcal", trcal_out, 10'h155);
        finish_done(1);

        // tx_busy abort after 3 bits
        pq.delete();
        push_bits(3'b110, 3);
        play(1'b0, 1'b0, 10'($urandom));
        tx_busy = 1'b1;
        m_phase = 0;
        repeat (4) begin
            @(negedge clk);
            check("busy_hold", rx_reset, 1);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_rearm", rx_reset, 1);
        @(negedge clk);
        check("busy_release", rx_reset, 0);
        check("busy_bits", pkt_bits, 0);

        // Overflow with no bits: silent re-arm
        wait_listen();
        send_overflow();
        check("silent_rearm", rx_reset, 1);

        // Variable-length packet hitting MAX_BITS
        pq.delete();
        push_bits(4'b1011, 4);
        push_rand(123);
        play(1'b0, 1'b0, 10'($urandom));
        check("max_rearm", rx_reset, 1);
        check("max_novalid", pkt_valid, 0);

        // Randomized packets
        for (int k = 0; k < 40; k++) run_random($urandom_range(0, 7));

        // Asynchronous reset mid-packet
        pq.delete();
        push_bits(2'b01, 2);
        play(1'b0, 1'b0, 10'h3FF);
        m_en = 1'b0;
        reset = 1'b0;
        #1;
        check("async_rx_reset", rx_reset, 1);
        check("async_bits", pkt_bits, 0);
        check("async_data", pkt_data, 0);
        check("async_valid", pkt_valid, 0);
        check("async_trcal", trcal_out, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
